// File: rtl/reverse_frame_arbiter.sv
// Two-requester frame arbiter with ping-pong banks; each N-word frame is replayed in reverse order.
// Define REV_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default build is round-robin per frame.
module reverse_frame_arbiter #(
   parameter int BITS = 8,
   parameter int N    = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      req_valid,
   input  logic [BITS-1:0] req_data0,
   input  logic [BITS-1:0] req_data1,
   output logic [1:0]      req_ready,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BITS-1:0] out_data,
   output logic            out_id,
   output logic            out_last,
   output logic            busy
);

   localparam int AW = (N > 1) ? $clog2(N) : 1;
   localparam logic [AW-1:0] LAST = AW'(N - 1);

   typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_e;
   typedef enum logic {W_IDLE, W_FILL} wstate_e;
   typedef enum logic {R_IDLE, R_DRAIN} rstate_e;

   bank_e           bank_st  [2];
   logic            bank_own [2];
   logic [BITS-1:0] mem      [2][N];

   wstate_e         w_state;
   rstate_e         r_state;
   logic            wr_ptr, rd_ptr, grant, pick, accept, load;
   logic [AW-1:0]   wr_addr, rd_addr;
   logic [BITS-1:0] wdata;
`ifndef REV_ARB_FIXED_PRIO_EN
   logic            rr_prio;
`endif

   assign req_ready = (w_state == W_FILL) ? (grant ? 2'b10 : 2'b01) : 2'b00;
   assign accept    = (w_state == W_FILL) && req_valid[grant];
   assign load      = (r_state == R_DRAIN) && (!out_valid || out_ready);
   assign wdata     = grant ? req_data1 : req_data0;
   assign busy      = (bank_st[0] != B_EMPTY) || (bank_st[1] != B_EMPTY) || (w_state == W_FILL);

`ifdef REV_ARB_FIXED_PRIO_EN
   assign pick = !req_valid[0];
`else
   // rr_prio names the requester that wins a contested grant
   assign pick = (req_valid == 2'b11) ? rr_prio : req_valid[1];
`endif

   // Frame storage carries no reset: a bank is never read unless marked FULL
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr][wr_addr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            bank_st[i]  <= B_EMPTY;
            bank_own[i] <= 1'b0;
         end
         w_state   <= W_IDLE;
         r_state   <= R_IDLE;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         grant     <= 1'b0;
         wr_addr   <= '0;
         rd_addr   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= 1'b0;
         out_last  <= 1'b0;
`ifndef REV_ARB_FIXED_PRIO_EN
         rr_prio   <= 1'b0;
`endif
      end else begin
         // Write side: banks are claimed from registered state, so a bank freed
         // by the reader this edge is granted on the next edge at the earliest.
         case (w_state)
            W_IDLE: begin
               if (bank_st[wr_ptr] == B_EMPTY && |req_valid) begin
                  grant            <= pick;
                  w_state          <= W_FILL;
                  wr_addr          <= '0;
                  bank_st[wr_ptr]  <= B_FILLING;
`ifndef REV_ARB_FIXED_PRIO_EN
                  rr_prio          <= ~pick;
`endif
               end
            end
            W_FILL: begin
               if (req_valid[grant]) begin
                  if (wr_addr == LAST) begin
                     bank_st[wr_ptr]  <= B_FULL;
                     bank_own[wr_ptr] <= grant;
                     wr_ptr           <= ~wr_ptr;
                     w_state          <= W_IDLE;
                  end else begin
                     wr_addr <= wr_addr + 1'b1;
                  end
               end
            end
            default: w_state <= W_IDLE;
         endcase

         // Read side: walk the full bank from address N-1 down to 0
         case (r_state)
            R_IDLE: begin
               if (bank_st[rd_ptr] == B_FULL) begin
                  r_state <= R_DRAIN;
                  rd_addr <= LAST;
               end
            end
            R_DRAIN: begin
               if (load) begin
                  out_data <= mem[rd_ptr][rd_addr];
                  out_id   <= bank_own[rd_ptr];
                  out_last <= (rd_addr == '0);
                  if (rd_addr == '0) begin
                     bank_st[rd_ptr] <= B_EMPTY;
                     rd_ptr          <= ~rd_ptr;
                     rd_addr         <= LAST;
                     r_state         <= (bank_st[~rd_ptr] == B_FULL) ? R_DRAIN : R_IDLE;
                  end else begin
                     rd_addr <= rd_addr - 1'b1;
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase

         if (load)           out_valid <= 1'b1;
         else if (out_ready) out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/reverse_frame_arbiter.md
REVERSE_FRAME_ARBITER -- requirements
Module: reverse_frame_arbiter

Interface
REQ-001 SHALL have parameter BITS, default 8, meaning data word width.
REQ-002 SHALL have parameter N, default 10, meaning words per frame (N >= 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req_valid, input, 2, per-requester word valid.
REQ-006 SHALL have ports req_data0 / req_data1, input, BITS each, requester 0/1 data.
REQ-007 SHALL have port req_ready, output, 2, per-requester word accept.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1, out_data output BITS, out_id output 1 (source requester), out_last output 1 (final word of frame).
REQ-009 SHALL have port busy, output, 1, high when any bank is non-empty or a frame is being filled.

Function
REQ-010 SHALL contain two N-word banks (ping-pong); each bank is EMPTY, FILLING or FULL, with a stored owner id.
REQ-011 Write FSM SHALL have states W_IDLE and W_FILL; W_IDLE -> W_FILL at an edge where the write bank is EMPTY and any req_valid is high, registering the grant.
REQ-012 req_ready[g] SHALL be high only in W_FILL for granted requester g; req_ready[~g] SHALL be 0.
REQ-013 A word SHALL be accepted on req_valid[g] && req_ready[g]; word k (0..N-1) written to address k of the write bank.
REQ-014 On acceptance of word N-1: bank -> FULL with owner g, write-bank pointer toggles, FSM -> W_IDLE, grant released.
REQ-015 Arbitration (default build) SHALL be round-robin at frame granularity: requester granted last has lower priority next; after reset requester 0 has priority.
REQ-016 A grant SHALL persist for the whole frame regardless of req_valid gaps; no preemption.
REQ-017 If the write bank is not EMPTY, write FSM SHALL stay in W_IDLE with req_ready = 0.
REQ-018 Read FSM SHALL have states R_IDLE and R_DRAIN; R_IDLE -> R_DRAIN when the read bank is FULL.
REQ-019 R_DRAIN SHALL present addresses N-1 down to 0 of the read bank, one per output transfer.
REQ-020 out_data/out_id/out_last/out_valid SHALL be registered and loaded only when !out_valid || out_ready.
REQ-021 First word of a frame SHALL appear (out_valid=1) on the second rising edge after the edge accepting its last input word, absent back-pressure.
REQ-022 out_last SHALL be 1 only with the address-0 word; out_id SHALL equal bank owner for all N words.
REQ-023 Bank SHALL return to EMPTY at the edge its address-0 word is read into the output register; read pointer toggles, read FSM -> R_IDLE or directly R_DRAIN if next bank FULL.
REQ-024 With out_ready held high and both requesters streaming, sustained throughput SHALL be one word per cycle, excluding one grant cycle per frame.
REQ-025 out_valid && !out_ready SHALL hold all output registers stable.
REQ-026 Simultaneous bank release (read) and grant request (write) on the same bank SHALL grant one cycle later, never earlier.

Reset
REQ-027 rst_n low SHALL immediately force: out_valid 0, out_data 0, out_id 0, out_last 0, req_ready 0, busy 0, both banks EMPTY, both FSMs idle, pointers 0, RR priority requester 0.
REQ-028 Reset mid-frame SHALL discard all partial and full frames; no word of them appears after release.
REQ-029 First grant after rst_n rises SHALL occur no earlier than the first rising edge with rst_n high.

Configuration
REQ-030 Macro REV_ARB_FIXED_PRIO_EN SHALL, when defined, replace round-robin by fixed priority (requester 0 always wins a contested grant); when undefined, REQ-015 round-robin applies.

Verification (N=4, BITS=8)
REQ-031 Req0 sends 1,2,3,4; out_ready=1 -> out_data 4,3,2,1, out_id 0, out_last on 1, first out_valid 2 edges after word 4 accepted.
REQ-032 Both requesters valid continuously, data 0x1x / 0x2x -> frames alternate id 0,1,0,1 (fixed-prio build: id 0 only).
REQ-033 out_ready=0 for 10 cycles after frame A, B full -> req_ready 0 for third frame, outputs stable; on release A then B reverse exactly.
REQ-034 req_valid[0] dropped for 3 cycles mid-frame while req_valid[1] high -> req_ready[1] stays 0 until req0 frame completes.
REQ-035 rst_n pulsed low after 2 words accepted, one bank FULL -> all outputs 0 immediately; post-reset frame 5,6,7,8 outputs 8,7,6,5 only.
